// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI byte-level write decoder feeding an auto-incrementing bank of 8-bit config registers
module spi_reg_bank #(
  parameter int NUM_REGS = 16
) (
  input  logic                  spi_clk,
  input  logic                  rstn,
  input  logic                  csb,
  input  logic                  pico,
  input  logic [7:0]            byte_deser,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data
);
  typedef enum logic [1:0] {CMD, WRITE, DISCARD} state_t;
  localparam logic [7:0] LIMIT = 8'(NUM_REGS);
  state_t state, state_d;
  logic [2:0] bit_cnt;
  logic [6:0] ptr, ptr_d;
  logic [7:0] cur_byte;
  logic done, we;
  assign cur_byte = {byte_deser[6:0], pico};
  assign done = bit_cnt == 3'd7;
  // next state, pointer and write enable, all acting only on the byte-completing edge
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    we = 1'b0;
    if (done) begin
      state_d = state == CMD ? (cur_byte[7] ? WRITE : DISCARD) : state;
      ptr_d = state == CMD ? (cur_byte[7] ? cur_byte[6:0] : ptr) : state == WRITE ? ptr + 7'd1 : ptr;
      we = state == WRITE && {1'b0, ptr} < LIMIT;
    end
  end
  // frame state, held clear while csb is high so every frame restarts at a command byte
  always_ff @(posedge spi_clk or negedge rstn or posedge csb)
    if (!rstn || csb) begin
      bit_cnt <= '0;
      state <= CMD;
      ptr <= '0;
      wr_strobe <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      state <= state_d;
      ptr <= ptr_d;
      wr_strobe <= we;
    end
  // register bank and last-write record survive csb and clear only on rstn
  always_ff @(posedge spi_clk or negedge rstn)
    if (!rstn) begin
      regs_flat <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (ptr == 7'(i)) regs_flat[8*i +: 8] <= cur_byte;
      wr_addr <= ptr;
      wr_data <= cur_byte;
    end
endmodule
